// File: rtl/mem_stage_pkg.sv
// Shared encodings for the EX->MEM stage: access-size funct3 values, the
// load/store FSM state and the mem_err codes.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } mem_err_e;

endpackage

// File: rtl/mem_stage_pipe_lsu_align.sv
// Combinational lane logic: store byte enables/data and misalignment from the
// EX-side size and offset, and load byte/half extraction with extension.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_val,
  output logic        misaligned,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // st_size is funct3[1:0]: 00 byte, 01 half, anything else is a word.
  always_comb begin
    misaligned = 1'b0;
    st_be      = '1;
    st_wdata   = st_val;
    case (st_size)
      2'b00: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_val[7:0]}};
      end
      2'b01: begin
        misaligned = st_off[0];
        st_be      = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{st_val[15:0]}};
      end
      default: misaligned = |st_off;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'b0, ld_half};
      F3_W:    ld_data = ld_word;
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// EX->MEM pipeline register with an integrated load/store unit: one access in
// flight over a req/ack bus, EX stalled while BUSY, timeout and misalign errors.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int unsigned RD_W    = 5,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_wr_en,
  input  logic              ex_mem_en,
  input  logic              ex_mem_wr,
  input  logic [2:0]        ex_funct3,
  input  logic [RD_W-1:0]   ex_rd_sel,
  input  logic [31:0]       ex_alu_val,
  input  logic [31:0]       ex_store_val,
  input  logic              flush,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_valid,
  output logic              mem_wr_en,
  output logic [RD_W-1:0]   mem_rd_sel,
  output logic [31:0]       mem_result,
  output logic [1:0]        mem_err,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_sel,
  output logic [31:0]       fwd_val
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              dmem_req_q, dmem_we_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [3:0]        dmem_be_q;
  logic [31:0]       dmem_wdata_q;
  logic [2:0]        ld_f3_q;
  logic [1:0]        ld_off_q;
  logic [RD_W-1:0]   busy_rd_q;
  logic              mem_valid_q, mem_wr_en_q;
  logic [RD_W-1:0]   mem_rd_sel_q;
  logic [31:0]       mem_result_q;
  mem_err_e          mem_err_q;

  logic              misaligned;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;
  logic              ex_live, ex_start, cnt_last;

  assign ex_live  = ex_valid & ~flush;
  assign ex_start = ex_live & ex_mem_en & ~misaligned;
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  lsu_align u_align (
    .st_size    (ex_funct3[1:0]),
    .st_off     (ex_alu_val[1:0]),
    .st_val     (ex_store_val),
    .misaligned (misaligned),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (ld_f3_q),
    .ld_off     (ld_off_q),
    .ld_word    (dmem_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ex_start) state_d = BUSY;
      BUSY: if (dmem_ack || cnt_last) state_d = IDLE;
    endcase
  end

  always_comb begin
    stall     = (state_q == BUSY);
    fwd_valid = ex_live & ~stall & ex_wr_en & ~ex_mem_en & (ex_rd_sel != '0);
    fwd_sel   = ex_rd_sel;
    fwd_val   = ex_alu_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      ld_f3_q      <= '0;
      ld_off_q     <= '0;
      busy_rd_q    <= '0;
      mem_valid_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_sel_q <= '0;
      mem_result_q <= '0;
      mem_err_q    <= ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          // An aligned access leaves a bubble here; its result lands on ack.
          mem_valid_q  <= ex_live & ~(ex_mem_en & ~misaligned);
          mem_wr_en_q  <= ex_live & ex_wr_en & ~ex_mem_en & (ex_rd_sel != '0);
          mem_err_q    <= (ex_live & ex_mem_en & misaligned) ? ERR_MISALIGN : ERR_NONE;
          mem_rd_sel_q <= ex_rd_sel;
          mem_result_q <= ex_alu_val;
          cnt_q        <= '0;
          if (ex_start) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= ex_mem_wr;
            dmem_addr_q  <= {ex_alu_val[ADDR_W-1:2], 2'b00};
            dmem_be_q    <= st_be;
            dmem_wdata_q <= st_wdata;
            ld_f3_q      <= ex_funct3;
            ld_off_q     <= ex_alu_val[1:0];
            busy_rd_q    <= ex_rd_sel;
          end
        end
        BUSY: begin
          mem_rd_sel_q <= busy_rd_q;
          if (dmem_ack) begin
            dmem_req_q   <= 1'b0;
            mem_valid_q  <= 1'b1;
            mem_wr_en_q  <= ~dmem_we_q & (busy_rd_q != '0);
            mem_err_q    <= ERR_NONE;
            mem_result_q <= dmem_we_q ? '0 : ld_data;
            cnt_q        <= '0;
          end else if (cnt_last) begin
            dmem_req_q   <= 1'b0;
            mem_valid_q  <= 1'b1;
            mem_wr_en_q  <= 1'b0;
            mem_err_q    <= ERR_TIMEOUT;
            mem_result_q <= '0;
            cnt_q        <= '0;
          end else begin
            mem_valid_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_err_q    <= ERR_NONE;
            cnt_q        <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_rd_sel = mem_rd_sel_q;
  assign mem_result = mem_result_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed cases then random instructions, each
// compared against a transaction-level model of the memory stage.
module tb_mem_stage_pipe;

  localparam int unsigned RD_W    = 5;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_wr_en, ex_mem_en, ex_mem_wr;
  logic [2:0]        ex_funct3;
  logic [RD_W-1:0]   ex_rd_sel;
  logic [31:0]       ex_alu_val, ex_store_val;
  logic              flush;
  logic              stall, dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;
  logic              mem_valid, mem_wr_en;
  logic [RD_W-1:0]   mem_rd_sel;
  logic [31:0]       mem_result;
  logic [1:0]        mem_err;
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_sel;
  logic [31:0]       fwd_val;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mem_stage_pipe #(
    .RD_W    (RD_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_wr_en     (ex_wr_en),
    .ex_mem_en    (ex_mem_en),
    .ex_mem_wr    (ex_mem_wr),
    .ex_funct3    (ex_funct3),
    .ex_rd_sel    (ex_rd_sel),
    .ex_alu_val   (ex_alu_val),
    .ex_store_val (ex_store_val),
    .flush        (flush),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .mem_valid    (mem_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_sel   (mem_rd_sel),
    .mem_result   (mem_result),
    .mem_err      (mem_err),
    .fwd_valid    (fwd_valid),
    .fwd_sel      (fwd_sel),
    .fwd_val      (fwd_val)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned nb = nbytes(f3);
    return 32'(((1 << nb) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sv);
    int unsigned nb = nbytes(f3);
    if (nb == 1) return {24'b0, sv[7:0]} * 32'h0101_0101;
    if (nb == 2) return {16'b0, sv[15:0]} * 32'h0001_0001;
    return sv;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned nb = nbytes(f3);
    logic [31:0] v, m;
    if (nb == 4) return word;
    v = word >> (8 * (addr % 4));
    m = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = v & m;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  // Presents one EX instruction, plays the memory side with an ack in cycle
  // ack_at of the access (beyond TIMEOUT means never), and checks the outcome.
  task automatic run_op(input logic v, input logic wr, input logic men, input logic mwr,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] sv, input logic fl, input logic fl_busy,
                        input int unsigned ack_at, input logic [31:0] rdata);
    logic live, mis, busy;
    live = v & ~fl;
    mis  = men && ((alu % nbytes(f3)) != 0);
    busy = live & men & ~mis;
    @(negedge clk);
    ex_valid = v; ex_wr_en = wr; ex_mem_en = men; ex_mem_wr = mwr; ex_funct3 = f3;
    ex_rd_sel = rd; ex_alu_val = alu; ex_store_val = sv; flush = fl;
    #1;
    check_val("fwd_valid", 32'(fwd_valid), 32'(live & wr & ~men & (rd != 0)));
    check_val("fwd_val", fwd_val, alu);
    @(posedge clk); #1;
    if (!busy) begin
      check_val("valid", 32'(mem_valid), 32'(live));
      check_val("wr_en", 32'(mem_wr_en), 32'(live & ~men & wr & (rd != 0)));
      check_val("err", 32'(mem_err), (live & mis) ? 32'd1 : 32'd0);
      check_val("stall_idle", 32'(stall), 32'd0);
      check_val("req_idle", 32'(dmem_req), 32'd0);
      if (live && !men) begin
        check_val("alu_result", mem_result, alu);
        check_val("alu_rd", 32'(mem_rd_sel), 32'(rd));
      end
    end else begin
      check_val("accept_bubble", 32'(mem_valid), 32'd0);
      for (int unsigned c = 1; c <= TIMEOUT; c++) begin
        check_val("stall_busy", 32'(stall), 32'd1);
        check_val("req_busy", 32'(dmem_req), 32'd1);
        check_val("we", 32'(dmem_we), 32'(mwr));
        check_val("addr", 32'(dmem_addr), alu & 32'hFFFF_FFFC);
        if (mwr) begin
          check_val("be", 32'(dmem_be), model_be(f3, alu));
          check_val("wdata", dmem_wdata, model_wdata(f3, sv));
        end
        @(negedge clk);
        flush = fl_busy;
        dmem_ack   = (c == ack_at);
        dmem_rdata = (c == ack_at) ? rdata : $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        flush    = 1'b0;
        if (c == ack_at) begin
          check_val("done_valid", 32'(mem_valid), 32'd1);
          check_val("done_wr_en", 32'(mem_wr_en), 32'(~mwr & (rd != 0)));
          check_val("done_err", 32'(mem_err), 32'd0);
          check_val("done_rd", 32'(mem_rd_sel), 32'(rd));
          if (!mwr) check_val("load_result", mem_result, model_load(f3, alu, rdata));
          check_val("done_req", 32'(dmem_req), 32'd0);
          check_val("done_stall", 32'(stall), 32'd0);
          break;
        end else if (c == TIMEOUT) begin
          check_val("to_valid", 32'(mem_valid), 32'd1);
          check_val("to_wr_en", 32'(mem_wr_en), 32'd0);
          check_val("to_err", 32'(mem_err), 32'd2);
          check_val("to_req", 32'(dmem_req), 32'd0);
          check_val("to_stall", 32'(stall), 32'd0);
        end else begin
          check_val("busy_valid", 32'(mem_valid), 32'd0);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req"}, 32'(dmem_req), 32'd0);
    check_val({tag, "_we"}, 32'(dmem_we), 32'd0);
    check_val({tag, "_addr"}, 32'(dmem_addr), 32'd0);
    check_val({tag, "_be"}, 32'(dmem_be), 32'd0);
    check_val({tag, "_wdata"}, dmem_wdata, 32'd0);
    check_val({tag, "_valid"}, 32'(mem_valid), 32'd0);
    check_val({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    check_val({tag, "_rd"}, 32'(mem_rd_sel), 32'd0);
    check_val({tag, "_result"}, mem_result, 32'd0);
    check_val({tag, "_err"}, 32'(mem_err), 32'd0);
    check_val({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] f3_tab [7];
    logic [2:0] f3;
    logic [4:0] rd;
    logic       men;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

    rst = 1'b1; ex_valid = 0; ex_wr_en = 0; ex_mem_en = 0; ex_mem_wr = 0; ex_funct3 = 0;
    ex_rd_sel = 0; ex_alu_val = 0; ex_store_val = 0; flush = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // ALU op, lb, sh, misaligned lw, lhu, timeout, flush while busy, rd=0 ALU op
    run_op(1, 1, 0, 0, 3'd0, 5'd5, 32'h0000_1234, 32'h0, 0, 0, 0, 32'h0);
    run_op(1, 1, 1, 0, 3'd0, 5'd9, 32'h0000_0103, 32'h0, 0, 0, 3, 32'h80FF_FF7F);
    run_op(1, 0, 1, 1, 3'd1, 5'd0, 32'h0000_0102, 32'h0000_ABCD, 0, 0, 2, 32'h0);
    run_op(1, 1, 1, 0, 3'd2, 5'd4, 32'h0000_0102, 32'h0, 0, 0, 1, 32'h0);
    run_op(1, 1, 1, 0, 3'd5, 5'd6, 32'h0000_0102, 32'h0, 0, 0, 1, 32'h8001_0000);
    run_op(1, 1, 1, 0, 3'd2, 5'd8, 32'h0000_0200, 32'h0, 0, 0, 99, 32'h0);
    run_op(1, 1, 1, 0, 3'd2, 5'd8, 32'h0000_0204, 32'h0, 0, 0, TIMEOUT, 32'h5A5A_1234);
    run_op(1, 0, 1, 1, 3'd2, 5'd0, 32'h0000_0300, 32'hDEAD_BEEF, 0, 1, 4, 32'h0);
    run_op(1, 1, 0, 0, 3'd0, 5'd0, 32'h0000_0777, 32'h0, 0, 0, 0, 32'h0);
    run_op(1, 1, 0, 0, 3'd0, 5'd3, 32'h0000_0555, 32'h0, 1, 0, 0, 32'h0);

    // Reset in the second BUSY cycle; an ack arriving afterwards is ignored.
    @(negedge clk);
    ex_valid = 1; ex_wr_en = 1; ex_mem_en = 1; ex_mem_wr = 0; ex_funct3 = 3'd2;
    ex_rd_sel = 5'd7; ex_alu_val = 32'h0000_0400; flush = 0;
    @(posedge clk); #1;
    check_val("rst_seq_req1", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    check_val("rst_seq_req2", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; ex_valid = 0;
    @(posedge clk); #1;
    check_all_zero("busy_reset");
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_val("late_ack_valid", 32'(mem_valid), 32'd0);
    check_val("late_ack_req", 32'(dmem_req), 32'd0);
    check_val("late_ack_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 200; i++) begin
      f3  = f3_tab[$urandom_range(0, 6)];
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      men = ($urandom_range(0, 2) != 0);
      run_op(($urandom_range(0, 7) != 0), 1'($urandom), men, 1'($urandom), f3, rd,
             {20'h0, 12'($urandom)}, $urandom, ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(1, 5), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
